// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, one-entry output register to decode.
// Optional IFU_MISALIGN_CHECK_EN turns a misaligned fetch_pc into a faulting NOP without a memory access.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_fault,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              drop;
  logic              misaligned;
  logic              req_fire;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned = |fetch_pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req_valid = (state == REQ) && !misaligned && !rst;
  assign mem_req_addr  = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign req_fire      = mem_req_valid && mem_req_ready;

  // NOTE: all state, including the output register, lives in one clocked block with
  // non-blocking assignments and a synchronous reset; no combinational next-state copy exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      fetch_pc  <= RESET_PC;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
      out_pc    <= RESET_PC;
      out_fault <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (req_fire) begin
              // The in-flight request now targets a stale PC; discard its response.
              state <= WAIT;
              drop  <= 1'b1;
            end
          end else if (req_fire) begin
            state <= WAIT;
          end else if (misaligned) begin
            out_valid <= 1'b1;
            out_fault <= 1'b1;
            out_inst  <= NOP_INST;
            out_pc    <= fetch_pc;
            state     <= HOLD;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (mem_rsp_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (mem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              out_valid <= 1'b1;
              out_inst  <= mem_rsp_data;
              out_pc    <= fetch_pc;
              out_fault <= mem_rsp_err;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // A redirect alongside out_ready still delivers the held instruction.
          if (out_ready || redirect_valid) begin
            out_valid <= 1'b0;
            state     <= REQ;
            fetch_pc  <= redirect_valid ? redirect_pc : out_pc + ADDR_W'(4);
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Replaces the combinational DPI instruction read with a request/response memory port. Owns the fetch PC.
- Delivers {inst, pc, fault} to decode over a valid/ready handshake. Accepts PC redirects (branch, jump, trap) from the execute/PC logic.
- At most one outstanding memory request and a one-entry output register.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  fetch address, word aligned
- mem_rsp_valid  in  1  response valid, single-cycle pulse
- mem_rsp_data  in  32  instruction word
- mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_inst  out  32  instruction
- out_pc  out  ADDR_W  PC of out_inst
- out_fault  out  1  instruction carries fetch fault
- redirect_valid  in  1  load new PC
- redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=1 at posedge):
  - state=REQ, fetch_pc=RESET_PC, drop=0.
  - out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=RESET_PC, out_fault=0.
  - mem_req_valid is 0 while rst is high.
- Memory-side reset: the memory side shares rst, so no pre-reset response arrives after reset. Reset mid-operation abandons any request or buffered instruction.
- State REQ:
  - mem_req_valid=1, mem_req_addr=fetch_pc.
  - mem_req_valid && mem_req_ready -> WAIT.
  - Address may change before acceptance only due to redirect.
- State WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid with drop=0:
    - out_inst=mem_rsp_data, out_pc=fetch_pc, out_fault=mem_rsp_err, out_valid=1.
    - Go to HOLD.
  - On mem_rsp_valid with drop=1: discard the response, clear drop, go to REQ. fetch_pc already holds the redirect target.
- State HOLD:
  - out_valid=1; outputs are stable until accepted.
  - out_ready=1: handshake completes; fetch_pc=out_pc+4 (modulo 2^ADDR_W, wraps); go to REQ.
  - Next request is issued the cycle after acceptance. Throughput is 1 instruction per 3 cycles minimum with 1-cycle memory.
- Redirect, highest priority, per state:
  - REQ, not accepted: fetch_pc=redirect_pc. The new address is presented next cycle.
  - REQ, accepted same cycle: go to WAIT, drop=1, fetch_pc=redirect_pc.
  - WAIT: drop=1, fetch_pc=redirect_pc. A response in the same cycle is dropped; go to REQ.
  - HOLD, out_ready=0: out_valid cleared next cycle, fetch_pc=redirect_pc, go to REQ.
  - HOLD, out_ready=1: the instruction is delivered (handshake counts), next fetch_pc=redirect_pc, not out_pc+4.
  - A redirect while drop=1 overwrites fetch_pc; drop stays 1.
- out_valid never deasserts without a handshake except on redirect or reset.
- Responses arriving in REQ or HOLD are protocol errors and are ignored.
- Fault handling: an instruction with out_fault=1 is delivered normally. Decode raises the exception. Fetch continues at pc+4 unless redirected.

Optional Feature:
- Macro: IFU_MISALIGN_CHECK_EN.
- Defined:
  - In REQ, if fetch_pc[1:0]!=0, no memory request is issued.
  - Next cycle: out_valid=1, out_fault=1, out_inst=NOP, out_pc=fetch_pc; go to HOLD.
  - Redirect rules apply unchanged.
- Undefined: no check; mem_req_addr={fetch_pc[ADDR_W-1:2],2'b00}.

Decomposition:
- Package ifu_pkg:
  - state enum {REQ, WAIT, HOLD} (2 bits).
  - NOP_INST=32'h0000_0013.
  - RESET_PC_DEFAULT.
- Single module. No sub-module is natural; the output register is part of the FSM.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle responses 0x00500093, 0x00108113, out_ready=1 -> mem_req_addr 0x80000000 then 0x80000004; out_pc 0x80000000/0x80000004 with matching out_inst.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_inst, out_pc stable; no mem_req_valid; release -> next addr = out_pc+4.
- Redirect in WAIT to 0x80000100, response 0xDEADBEEF one cycle later -> response dropped; next request at 0x80000100; its response delivered with out_pc=0x80000100.
- Redirect to 0x80000200 with out_ready=1 in HOLD -> current instruction handshaken once; next request at 0x80000200, not pc+4.
- mem_rsp_err=1 at 0x80000008 -> out_fault=1, out_pc=0x80000008; next fetch 0x8000000C. With IFU_MISALIGN_CHECK_EN, redirect 0x80000102 -> no mem request; out_fault=1, out_inst=0x00000013.
- Assert rst while in WAIT, then release -> out_valid=0; the first request after release is 0x80000000.
